gat_bram_load_bridge: RTL and testbench
=======================================

# gat_bram_load_bridge

Multi-channel host-to-core BRAM write bridge for the GAT accelerator. It accepts 32-bit, byte-addressed host BRAM writes per channel and assembles `LANES` consecutive words into one `DATA_W`-bit core entry. It commits each completed entry to the core BRAM port and tracks per-channel load completion. It sits between the PS-facing register/BRAM interface and `gat_top`, and replaces per-port bit slicing with a width-generic, counted load path.

## Interface
Parameters:
- `TOP_WIDTH`, 32: host data word width.
- `NUM_CH`, 3: number of independent channels (H data, node info, weight).
- `DATA_W`, 64: core entry width, applied uniformly to all channels.
- `DEPTH`, 13264: core entries per channel that constitute a complete load.
- `ADDR_W`, `$clog2(DEPTH)`: core entry address width.
- `LANES`, `(DATA_W+TOP_WIDTH-1)/TOP_WIDTH`: host words per entry.
- `LANE_W`, `(LANES>1)?$clog2(LANES):1`: lane index width.
- `HADDR_W`, `ADDR_W+LANE_W+2`: host byte-address width.

Ports (vectors are flattened; channel c occupies slice c):
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_din`  in  NUM_CH*TOP_WIDTH  host write data.
- `host_ena`  in  NUM_CH  host port enable.
- `host_wea`  in  NUM_CH  host write enable.
- `host_addra`  in  NUM_CH*HADDR_W  host byte address.
- `load_clr`  in  NUM_CH  synchronous clear of channel load state.
- `core_din`  out  NUM_CH*DATA_W  assembled entry.
- `core_we`  out  NUM_CH  one-cycle commit strobe.
- `core_addr`  out  NUM_CH*ADDR_W  entry address.
- `load_done`  out  NUM_CH  sticky: DEPTH entries committed.
- `err_partial`  out  NUM_CH  sticky: incomplete entry discarded.
- `err_range`  out  NUM_CH  sticky: out-of-range entry dropped (macro only).

## Operation
- A host write is accepted when `host_ena & host_wea`. The word index is `host_addra[HADDR_W-1:2]`.
  - Lane = `index[LANE_W-1:0]`. When `LANES==1`, lane is 0 and the entry address is the full index.
  - Entry address E = `index[HADDR_W-3:LANE_W]`.
  - Byte-address bits [1:0] are ignored.
- Lanes with index ≥ LANES are ignored when LANES is not a power of two.
- Each channel holds an assembly buffer, an entry tag, a `LANES`-bit valid mask, and a commit counter of `ADDR_W+1` bits.
- Per-channel states:
  - EMPTY (mask 0): an accepted write stores the lane, sets the tag to E, and goes to PARTIAL. If LANES==1 the write completes immediately.
  - PARTIAL:
    - Same E: store or overwrite the lane. Rewriting a lane is not an error.
    - Different E: the partial entry is discarded and `err_partial` is set. The new write starts a fresh entry.
  - Complete (mask all ones after the current write): at the next edge, register `core_din`/`core_addr` and pulse `core_we` for 1 cycle. Clear the mask (back to EMPTY) and increment the counter.
- Lane k occupies `core_din` bits [k*TOP_WIDTH +: TOP_WIDTH]. The top lane is truncated to `DATA_W`.
- The counter saturates at DEPTH. `load_done` is set when the counter reaches DEPTH.
- `load_clr` clears the counter, mask, `load_done`, `err_partial` and `err_range` of its channel.
  - If `load_clr` and a write occur in the same cycle, clear wins and the write is dropped.
  - A commit pulse already registered still issues.
- Channels are fully independent and may commit in the same cycle.

## Timing
- Reset (asynchronous assert): all outputs 0, all masks and counters 0.
- Latency: 1 cycle from the accepting edge of the completing lane to `core_we` high.
- No backpressure:
  - A write is accepted every cycle.
  - A new entry may start in the cycle `core_we` is high.
  - Back-to-back full entries with LANES=1 give `core_we` high every cycle.
- `load_done` rises 1 cycle after the DEPTH-th `core_we` edge.
- Reset mid-assembly discards the partial entry without setting an error flag.

## Configuration
- `GAT_BRIDGE_ADDR_CHECK_EN` defined:
  - A write with E ≥ DEPTH is dropped: no buffer change, no commit.
  - The channel's `err_range` is set.
- Macro undefined:
  - No range check; `err_range` is tied to 0.
  - E is truncated to ADDR_W bits and forwarded as is.

## Test plan
- LANES=2, ch0: write 0xA at byte 0x0 and 0xB at byte 0x4 → 1 cycle later `core_we[0]`=1, `core_addr`=0, `core_din`=0x0000000B_0000000A.
- Lanes written out of order (byte 0xC, then 0x8) → single commit to E=1 with the same lane placement.
- Lane 0 of E=2, then lane 0 of E=3 → `err_partial`=1, no commit for E=2, and E=3 completes normally afterwards.
- DEPTH=4, full sequential load on ch1 → 4 `core_we` pulses, `load_done[1]`=1 one cycle after the last; ch0/ch2 flags remain 0.
- `load_clr` in the same cycle as a completing write → no commit follows; counter, done and error flags read 0.
- Macro defined, DEPTH=5, write to E=6 → `err_range`=1, no `core_we`. Macro undefined → commit issues to E=6 and `err_range`=0.

Source files
------------

// File: rtl/gat_bram_load_bridge.sv
// Multi-channel host-to-core BRAM write bridge: packs LANES host words into one core entry per channel.
// Optional entry-address range check is enabled by defining GAT_BRIDGE_ADDR_CHECK_EN.
module gat_bram_load_bridge #(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 13264,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LANES     = (DATA_W + TOP_WIDTH - 1) / TOP_WIDTH,
  parameter int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int HADDR_W   = ADDR_W + LANE_W + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*TOP_WIDTH-1:0] host_din,
  input  logic [NUM_CH-1:0]           host_ena,
  input  logic [NUM_CH-1:0]           host_wea,
  input  logic [NUM_CH*HADDR_W-1:0]   host_addra,
  input  logic [NUM_CH-1:0]           load_clr,
  output logic [NUM_CH*DATA_W-1:0]    core_din,
  output logic [NUM_CH-1:0]           core_we,
  output logic [NUM_CH*ADDR_W-1:0]    core_addr,
  output logic [NUM_CH-1:0]           load_done,
  output logic [NUM_CH-1:0]           err_partial,
  output logic [NUM_CH-1:0]           err_range
);

  localparam int IDX_W = HADDR_W - 2;
  localparam int BUF_W = LANES * TOP_WIDTH;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [TOP_WIDTH-1:0] din_w;
      logic [IDX_W-1:0]     idx_w;
      logic                 wr_w;
      logic [LANE_W-1:0]    lane_w;
      logic [ADDR_W:0]      e_full_w;
      logic [ADDR_W-1:0]    e_w;
      logic                 range_bad_w;
      logic                 addr_unused_w;

      logic [LANES-1:0]     lane_hot_w;
      logic [BUF_W-1:0]     asm_w;
      logic [LANES-1:0]     mask_new_w;
      logic                 accept_w;
      logic                 restart_w;
      logic                 complete_w;

      logic [BUF_W-1:0]     buf_q;
      logic [ADDR_W-1:0]    tag_q;
      logic [LANES-1:0]     mask_q;
      logic [CNT_W-1:0]     cnt_q;
      logic [DATA_W-1:0]    core_din_q;
      logic [ADDR_W-1:0]    core_addr_q;
      logic                 core_we_q;
      logic                 done_q;
      logic                 errp_q;
      logic                 errr_q;

      assign din_w = host_din[gi*TOP_WIDTH +: TOP_WIDTH];
      assign idx_w = host_addra[gi*HADDR_W + 2 +: IDX_W];
      assign wr_w  = host_ena[gi] & host_wea[gi];

      // With a single lane the whole word index is the entry address (one extra bit kept for the range check).
      if (LANES == 1) begin : g_one_lane
        assign lane_w   = '0;
        assign e_full_w = idx_w;
      end else begin : g_multi_lane
        assign lane_w   = idx_w[LANE_W-1:0];
        assign e_full_w = {1'b0, idx_w[IDX_W-1:LANE_W]};
      end
      assign e_w = e_full_w[ADDR_W-1:0];

`ifdef GAT_BRIDGE_ADDR_CHECK_EN
      assign range_bad_w = (e_full_w >= DEPTH_CNT);
`else
      assign range_bad_w = 1'b0;
`endif
      assign addr_unused_w = ^host_addra[gi*HADDR_W +: 2] ^ e_full_w[ADDR_W];

      // Lane decode doubles as the lane-valid check: an index >= LANES matches no lane.
      always_comb begin
        lane_hot_w = '0;
        asm_w      = buf_q;
        for (int k = 0; k < LANES; k++) begin
          if (lane_w == LANE_W'(k)) begin
            lane_hot_w[k]                    = 1'b1;
            asm_w[k*TOP_WIDTH +: TOP_WIDTH] = din_w;
          end
        end
      end

      assign accept_w   = wr_w & (|lane_hot_w) & ~load_clr[gi] & ~range_bad_w;
      assign restart_w  = accept_w & (|mask_q) & (tag_q != e_w);
      assign mask_new_w = (restart_w ? '0 : mask_q) | lane_hot_w;
      assign complete_w = accept_w & (&mask_new_w);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_q       <= '0;
          tag_q       <= '0;
          mask_q      <= '0;
          cnt_q       <= '0;
          core_din_q  <= '0;
          core_addr_q <= '0;
          core_we_q   <= 1'b0;
          done_q      <= 1'b0;
          errp_q      <= 1'b0;
          errr_q      <= 1'b0;
        end else begin
          core_we_q <= 1'b0;
          if (load_clr[gi]) begin
            mask_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            errp_q <= 1'b0;
            errr_q <= 1'b0;
          end else begin
            if (cnt_q == DEPTH_CNT) begin
              done_q <= 1'b1;
            end
            if (wr_w && (|lane_hot_w) && range_bad_w) begin
              errr_q <= 1'b1;
            end
            if (accept_w) begin
              buf_q <= asm_w;
              tag_q <= e_w;
              if (restart_w) begin
                errp_q <= 1'b1;
              end
              if (complete_w) begin
                mask_q      <= '0;
                core_we_q   <= 1'b1;
                core_din_q  <= asm_w[DATA_W-1:0];
                core_addr_q <= e_w;
                if (cnt_q != DEPTH_CNT) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end else begin
                mask_q <= mask_new_w;
              end
            end
          end
        end
      end

      assign core_din[gi*DATA_W +: DATA_W]  = core_din_q;
      assign core_addr[gi*ADDR_W +: ADDR_W] = core_addr_q;
      assign core_we[gi]     = core_we_q;
      assign load_done[gi]   = done_q;
      assign err_partial[gi] = errp_q;
      assign err_range[gi]   = errr_q;
    end
  endgenerate

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Randomized and directed bench for gat_bram_load_bridge against an entry-level reference model.
module tb_gat_bram_load_bridge;
  localparam int TW = 32, NCH = 3, DW = 64, DEP = 5;
  localparam int AW = 3, LN = 2, LW = 1, HW = AW + LW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*TW-1:0] host_din;
  logic [NCH-1:0]    host_ena, host_wea, load_clr;
  logic [NCH*HW-1:0] host_addra;
  logic [NCH*DW-1:0] core_din;
  logic [NCH-1:0]    core_we, load_done, err_partial, err_range;
  logic [NCH*AW-1:0] core_addr;

  gat_bram_load_bridge #(.TOP_WIDTH(TW), .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .host_din(host_din), .host_ena(host_ena), .host_wea(host_wea),
    .host_addra(host_addra), .load_clr(load_clr), .core_din(core_din), .core_we(core_we),
    .core_addr(core_addr), .load_done(load_done), .err_partial(err_partial), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Stimulus per channel.
  logic [31:0] d_din [NCH];
  logic [5:0]  d_addr[NCH];
  bit d_ena[NCH], d_wea[NCH], d_clr[NCH];

  always_comb begin
    host_din = '0; host_addra = '0; host_ena = '0; host_wea = '0; load_clr = '0;
    for (int c = 0; c < NCH; c++) begin
      host_din[c*TW +: TW]   = d_din[c];
      host_addra[c*HW +: HW] = d_addr[c];
      host_ena[c] = d_ena[c];
      host_wea[c] = d_wea[c];
      load_clr[c] = d_clr[c];
    end
  end

  // Reference model: the entry being gathered, which lanes it has, commits so far and sticky flags.
  bit          m_seen[NCH][LN];
  logic [31:0] m_word[NCH][LN];
  int          m_tag[NCH], m_cnt[NCH];
  bit          m_done[NCH], m_errp[NCH], m_errr[NCH], e_we[NCH];
  logic [63:0] e_din[NCH];
  int          e_addr[NCH];

  int n_cmp = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < LN; k++) begin m_seen[c][k] = 0; m_word[c][k] = '0; end
      m_tag[c] = 0; m_cnt[c] = 0; m_done[c] = 0; m_errp[c] = 0; m_errr[c] = 0;
      e_we[c] = 0; e_din[c] = '0; e_addr[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit nd, any, all, drop;
      int idx, lane, ent;
      nd = d_clr[c] ? 1'b0 : (m_done[c] || m_cnt[c] == DEP);
      e_we[c] = 0;
      if (d_clr[c]) begin
        for (int k = 0; k < LN; k++) m_seen[c][k] = 0;
        m_cnt[c] = 0; m_errp[c] = 0; m_errr[c] = 0;
      end else if (d_ena[c] && d_wea[c]) begin
        idx = int'(d_addr[c]) / 4;
        lane = idx % LN;
        ent = idx / LN;
        drop = 0;
`ifdef GAT_BRIDGE_ADDR_CHECK_EN
        drop = (ent >= DEP);
`endif
        if (drop) m_errr[c] = 1;
        else begin
          any = 0;
          for (int k = 0; k < LN; k++) any |= m_seen[c][k];
          if (any && m_tag[c] != ent) begin
            m_errp[c] = 1;
            for (int k = 0; k < LN; k++) m_seen[c][k] = 0;
          end
          m_seen[c][lane] = 1;
          m_word[c][lane] = d_din[c];
          m_tag[c] = ent;
          all = 1;
          for (int k = 0; k < LN; k++) all &= m_seen[c][k];
          if (all) begin
            e_we[c] = 1;
            for (int k = 0; k < LN; k++) e_din[c][k*32 +: 32] = m_word[c][k];
            e_addr[c] = ent % (1 << AW);
            if (m_cnt[c] < DEP) m_cnt[c]++;
            for (int k = 0; k < LN; k++) m_seen[c][k] = 0;
          end
        end
      end
      m_done[c] = nd;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("ch%0d core_we", c), 64'(core_we[c]), 64'(e_we[c]));
      if (e_we[c] || core_we[c]) begin
        check_val($sformatf("ch%0d core_din", c), core_din[c*DW +: DW], e_din[c]);
        check_val($sformatf("ch%0d core_addr", c), 64'(core_addr[c*AW +: AW]), 64'(e_addr[c]));
      end
      check_val($sformatf("ch%0d load_done", c), 64'(load_done[c]), 64'(m_done[c]));
      check_val($sformatf("ch%0d err_partial", c), 64'(err_partial[c]), 64'(m_errp[c]));
      check_val($sformatf("ch%0d err_range", c), 64'(err_range[c]), 64'(m_errr[c]));
    end
  endtask

  task automatic clear_in();
    for (int c = 0; c < NCH; c++) begin
      d_din[c] = '0; d_addr[c] = '0; d_ena[c] = 0; d_wea[c] = 0; d_clr[c] = 0;
    end
  endtask

  task automatic set_wr(input int c, input int baddr, input logic [31:0] data);
    d_din[c] = data; d_addr[c] = 6'(baddr); d_ena[c] = 1; d_wea[c] = 1;
  endtask

  // One clock: edge, model update, sample 1 time unit later, then idle the inputs.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    clear_in();
  endtask

  int ptr[NCH];
  int pulses;

  initial begin
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_val("reset outputs", {core_din[63:0]}, 64'h0);
    check_val("reset flags", 64'({core_we, core_addr, load_done, err_partial, err_range}), 64'h0);
    check_val("reset ch1 din", core_din[127:64], 64'h0);

    // Two lanes in order.
    set_wr(0, 'h0, 32'hA); cyc();
    set_wr(0, 'h4, 32'hB); cyc();
    check_val("in-order we", 64'(core_we[0]), 64'h1);
    check_val("in-order din", core_din[63:0], 64'h0000000B_0000000A);
    check_val("in-order addr", 64'(core_addr[2:0]), 64'h0);

    // Lanes out of order.
    set_wr(0, 'hC, 32'h11); cyc();
    set_wr(0, 'h8, 32'h22); cyc();
    check_val("ooo din", core_din[63:0], 64'h00000011_00000022);
    check_val("ooo addr", 64'(core_addr[2:0]), 64'h1);

    // Abandoned partial entry.
    set_wr(0, 'h10, 32'h33); cyc();
    set_wr(0, 'h18, 32'h44); cyc();
    check_val("partial err", 64'(err_partial[0]), 64'h1);
    check_val("partial no commit", 64'(core_we[0]), 64'h0);
    set_wr(0, 'h1C, 32'h55); cyc();
    check_val("restart addr", 64'(core_addr[2:0]), 64'h3);
    check_val("restart din", core_din[63:0], 64'h00000055_00000044);

    d_clr[0] = 1; cyc();

    // Full sequential load on ch1.
    pulses = 0;
    for (int i = 0; i < DEP * LN; i++) begin
      set_wr(1, i * 4, 32'(i + 100)); cyc();
      if (core_we[1]) pulses++;
    end
    check_val("load pulses", 64'(pulses), 64'(DEP));
    check_val("done not yet", 64'(load_done[1]), 64'h0);
    cyc();
    check_val("done set", 64'(load_done[1]), 64'h1);
    check_val("other done", 64'({load_done[2], load_done[0], err_partial[0], err_partial[2]}), 64'h0);

    // Clear collides with a completing write on ch2.
    set_wr(2, 'h8, 32'h66); cyc();
    set_wr(2, 'h0, 32'h77); cyc();
    set_wr(2, 'h4, 32'h88); d_clr[2] = 1; cyc();
    check_val("clr no commit", 64'(core_we[2]), 64'h0);
    check_val("clr flags", 64'({err_partial[2], load_done[2]}), 64'h0);
    set_wr(2, 'h4, 32'h99); cyc();
    check_val("clr mask gone", 64'(core_we[2]), 64'h0);
    d_clr[2] = 1; cyc();

    // Entry beyond DEPTH.
    d_clr[1] = 1; cyc();
    set_wr(1, 'h30, 32'hAA); cyc();
    set_wr(1, 'h34, 32'hBB); cyc();
`ifdef GAT_BRIDGE_ADDR_CHECK_EN
    check_val("range err", 64'(err_range[1]), 64'h1);
    check_val("range drop", 64'(core_we[1]), 64'h0);
`else
    check_val("range err", 64'(err_range[1]), 64'h0);
    check_val("range commit addr", 64'({core_we[1], core_addr[5:3]}), 64'h0E);
`endif

    // Reset in the middle of an entry.
    set_wr(0, 'h0, 32'hCC); cyc();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    set_wr(0, 'h4, 32'hDD); cyc();
    check_val("rst discards", 64'({core_we[0], err_partial[0]}), 64'h0);

    // Random traffic with a bias toward sequential loads.
    for (int c = 0; c < NCH; c++) ptr[c] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        d_ena[c] = ($urandom % 4) != 0;
        d_wea[c] = ($urandom % 4) != 0;
        d_clr[c] = ($urandom % 60) == 0;
        d_din[c] = $urandom;
        if ($urandom % 2) begin
          d_addr[c] = 6'(ptr[c]);
          if (d_ena[c] && d_wea[c]) ptr[c] = (ptr[c] + 4) % (DEP * LN * 4);
        end else begin
          d_addr[c] = 6'($urandom % 64);
        end
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
